// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP transmit scheduler.
package udp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } sched_state_e;

    localparam logic [7:0] UDP_PROTO = 8'd17;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dest_port;
        logic [15:0] len;
        logic [31:0] dest_ip;
        logic        no_chksum;
    } udp_hdr_t;

endpackage

// File: rtl/udp_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_CH);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Shares one UDP encoder between NUM_CH requesters: arbitrates, latches the
// header, forwards payload, collects the checksum and resets the encoder.
module udp_tx_scheduler
    import udp_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          local_ip,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [16*NUM_CH-1:0] ch_src_port,
    input  logic [16*NUM_CH-1:0] ch_dest_port,
    input  logic [16*NUM_CH-1:0] ch_len,
    input  logic [32*NUM_CH-1:0] ch_dest_ip,
    input  logic [NUM_CH-1:0]    ch_no_chksum,
    input  logic [32*NUM_CH-1:0] ch_data,
    input  logic [NUM_CH-1:0]    ch_data_av,
    output logic [NUM_CH-1:0]    ch_grant,
    output logic [NUM_CH-1:0]    ch_done,
    output logic                 ch_err,
    output logic [15:0]          checksum_out,
    output logic [31:0]          enc_src_ip,
    output logic [31:0]          enc_dest_ip,
    output logic [31:0]          enc_data,
    output logic [15:0]          enc_src_port,
    output logic [15:0]          enc_dest_port,
    output logic [15:0]          enc_len,
    output logic                 enc_no_chksum,
    output logic                 enc_start,
    output logic                 enc_data_av,
    output logic                 enc_reset,
    input  logic                 enc_fin,
    input  logic [15:0]          enc_checksum
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

    sched_state_e      state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    udp_hdr_t          hdr_q, hdr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [15:0]       chk_q, chk_d;

    logic [NUM_CH-1:0] arb_grant;
    logic [IDX_W-1:0]  arb_idx;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arb (
        .req   (ch_req),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            grant_q <= '0;
            hdr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            chk_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            hdr_q   <= hdr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            chk_q   <= chk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        hdr_d   = hdr_q;
        cnt_d   = '0;
        err_d   = err_q;
        chk_d   = chk_q;
        case (state_q)
            ST_IDLE: begin
                if (|ch_req) begin
                    state_d         = ST_LAUNCH;
                    grant_d         = arb_grant;
                    idx_d           = arb_idx;
                    ptr_d           = (arb_idx == IDX_LAST) ? '0 : arb_idx + 1'b1;
                    err_d           = 1'b0;
                    hdr_d.src_port  = ch_src_port[16*arb_idx +: 16];
                    hdr_d.dest_port = ch_dest_port[16*arb_idx +: 16];
                    hdr_d.len       = ch_len[16*arb_idx +: 16];
                    hdr_d.dest_ip   = ch_dest_ip[32*arb_idx +: 32];
                    hdr_d.no_chksum = ch_no_chksum[arb_idx];
                end
            end
            ST_LAUNCH: state_d = ST_RUN;
            ST_RUN: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                // fin wins over a coincident timeout
                if (enc_fin) begin
                    state_d = ST_DONE;
                    err_d   = 1'b0;
                    chk_d   = enc_checksum;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    chk_d   = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ch_grant      = grant_q;
    assign ch_done       = (state_q == ST_DONE) ? grant_q : '0;
    assign ch_err        = (state_q == ST_DONE) && err_q;
    assign checksum_out  = chk_q;

    assign enc_src_ip    = local_ip;
    assign enc_dest_ip   = hdr_q.dest_ip;
    assign enc_src_port  = hdr_q.src_port;
    assign enc_dest_port = hdr_q.dest_port;
    assign enc_len       = hdr_q.len;
    assign enc_no_chksum = hdr_q.no_chksum;
    assign enc_data      = ch_data[32*idx_q +: 32];
    assign enc_start     = (state_q == ST_LAUNCH);
    assign enc_data_av   = ((state_q == ST_LAUNCH) || (state_q == ST_RUN))
                           && ch_data_av[idx_q];
    // encoder FIN is sticky, so clear it after every packet
    assign enc_reset     = reset || (state_q == ST_DONE);

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Directed self-checking bench for udp_tx_scheduler; the bench plays the encoder.
module tb_udp_tx_scheduler;

    localparam int NCH = 4;

    logic          clk;
    logic          reset;
    logic [31:0]   local_ip;
    logic [3:0]    ch_req;
    logic [63:0]   ch_src_port;
    logic [63:0]   ch_dest_port;
    logic [63:0]   ch_len;
    logic [127:0]  ch_dest_ip;
    logic [3:0]    ch_no_chksum;
    logic [127:0]  ch_data;
    logic [3:0]    ch_data_av;
    logic [3:0]    ch_grant;
    logic [3:0]    ch_done;
    logic          ch_err;
    logic [15:0]   checksum_out;
    logic [31:0]   enc_src_ip;
    logic [31:0]   enc_dest_ip;
    logic [31:0]   enc_data;
    logic [15:0]   enc_src_port;
    logic [15:0]   enc_dest_port;
    logic [15:0]   enc_len;
    logic          enc_no_chksum;
    logic          enc_start;
    logic          enc_data_av;
    logic          enc_reset;
    logic          enc_fin;
    logic [15:0]   enc_checksum;

    int tests = 0;
    int fails = 0;
    logic [3:0] rr_exp [4];

    udp_tx_scheduler #(
        .NUM_CH      (NCH),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .local_ip      (local_ip),
        .ch_req        (ch_req),
        .ch_src_port   (ch_src_port),
        .ch_dest_port  (ch_dest_port),
        .ch_len        (ch_len),
        .ch_dest_ip    (ch_dest_ip),
        .ch_no_chksum  (ch_no_chksum),
        .ch_data       (ch_data),
        .ch_data_av    (ch_data_av),
        .ch_grant      (ch_grant),
        .ch_done       (ch_done),
        .ch_err        (ch_err),
        .checksum_out  (checksum_out),
        .enc_src_ip    (enc_src_ip),
        .enc_dest_ip   (enc_dest_ip),
        .enc_data      (enc_data),
        .enc_src_port  (enc_src_port),
        .enc_dest_port (enc_dest_port),
        .enc_len       (enc_len),
        .enc_no_chksum (enc_no_chksum),
        .enc_start     (enc_start),
        .enc_data_av   (enc_data_av),
        .enc_reset     (enc_reset),
        .enc_fin       (enc_fin),
        .enc_checksum  (enc_checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b1;
        local_ip     = 32'h0A000001;
        ch_req       = '0;
        ch_src_port  = '0;
        ch_dest_port = '0;
        ch_len       = '0;
        ch_dest_ip   = '0;
        ch_no_chksum = '0;
        ch_data      = '0;
        ch_data_av   = '0;
        enc_fin      = 1'b0;
        enc_checksum = '0;

        // reset values
        tick();
        chk("rst_grant", ch_grant, 0);
        chk("rst_done", ch_done, 0);
        chk("rst_err", ch_err, 0);
        chk("rst_chk", checksum_out, 0);
        chk("rst_start", enc_start, 0);
        chk("rst_av", enc_data_av, 0);
        chk("rst_encrst", enc_reset, 1);
        chk("rst_len", enc_len, 0);
        reset = 1'b0;
        tick();
        chk("idle_encrst", enc_reset, 0);

        // single packet on ch2
        ch_req                = 4'b0100;
        ch_len[47:32]         = 16'd8;
        ch_src_port[47:32]    = 16'h1234;
        ch_dest_ip[95:64]     = 32'hC0A80002;
        ch_no_chksum          = 4'b0100;
        tick();
        chk("sp_grant", ch_grant, 4'b0100);
        chk("sp_start", enc_start, 1);
        chk("sp_len", enc_len, 8);
        chk("sp_sport", enc_src_port, 16'h1234);
        chk("sp_dip", enc_dest_ip, 32'hC0A80002);
        chk("sp_nochk", enc_no_chksum, 1);
        chk("sp_sip", enc_src_ip, 32'h0A000001);
        ch_data[95:64] = 32'hAAAA0001;
        ch_data_av     = 4'b0100;
        #1;
        chk("sp_av0", enc_data_av, 1);
        chk("sp_data0", enc_data, 32'hAAAA0001);
        tick();
        chk("sp_start_off", enc_start, 0);
        ch_data[95:64] = 32'hAAAA0002;
        #1;
        chk("sp_data1", enc_data, 32'hAAAA0002);
        tick();
        ch_data_av = 4'b0000;
        #1;
        chk("sp_av_off", enc_data_av, 0);
        tick();
        tick();
        chk("sp_nodone", ch_done, 0);
        enc_fin      = 1'b1;
        enc_checksum = 16'hBEEF;
        tick();
        chk("sp_done", ch_done, 4'b0100);
        chk("sp_err", ch_err, 0);
        chk("sp_chk", checksum_out, 16'hBEEF);
        chk("sp_encrst", enc_reset, 1);
        chk("sp_grant_done", ch_grant, 4'b0100);
        ch_req       = '0;
        enc_fin      = 1'b0;
        enc_checksum = '0;
        tick();
        chk("sp_done_off", ch_done, 0);
        chk("sp_grant_off", ch_grant, 0);
        chk("sp_chk_hold", checksum_out, 16'hBEEF);
        chk("sp_encrst_off", enc_reset, 0);

        // header latch and non-granted data_av on ch1
        ch_req         = 4'b0010;
        ch_len[31:16]  = 16'd12;
        ch_no_chksum   = 4'b0000;
        tick();
        chk("hl_grant", ch_grant, 4'b0010);
        chk("hl_len", enc_len, 12);
        ch_len[31:16] = 16'd40;
        ch_data_av    = 4'b1101;
        #1;
        chk("hl_len_hold", enc_len, 12);
        chk("ng_av_other", enc_data_av, 0);
        ch_data_av = 4'b0010;
        #1;
        chk("ng_av_own", enc_data_av, 1);
        tick();
        ch_data_av = 4'b1000;
        #1;
        chk("ng_av_run_other", enc_data_av, 0);
        ch_data_av = 4'b1010;
        #1;
        chk("ng_av_run_own", enc_data_av, 1);
        enc_fin      = 1'b1;
        enc_checksum = 16'h1234;
        tick();
        chk("hl_done", ch_done, 4'b0010);
        chk("hl_len_done", enc_len, 12);
        chk("hl_chk", checksum_out, 16'h1234);
        ch_req       = '0;
        enc_fin      = 1'b0;
        ch_data_av   = '0;
        tick();

        // timeout on ch0: DONE 16 cycles after RUN entry
        ch_req       = 4'b0001;
        enc_checksum = 16'h5555;
        tick();
        chk("to_grant", ch_grant, 4'b0001);
        tick();
        repeat (15) tick();
        chk("to_early", ch_done, 0);
        chk("to_encrst_early", enc_reset, 0);
        tick();
        chk("to_done", ch_done, 4'b0001);
        chk("to_err", ch_err, 1);
        chk("to_chk", checksum_out, 0);
        chk("to_encrst", enc_reset, 1);
        ch_req = '0;
        tick();
        chk("to_err_off", ch_err, 0);
        chk("to_encrst_off", enc_reset, 0);

        // fin coinciding with timeout counts as normal completion
        ch_req = 4'b0001;
        tick();
        tick();
        repeat (15) tick();
        enc_fin      = 1'b1;
        enc_checksum = 16'h7777;
        tick();
        chk("ft_done", ch_done, 4'b0001);
        chk("ft_err", ch_err, 0);
        chk("ft_chk", checksum_out, 16'h7777);
        ch_req  = '0;
        enc_fin = 1'b0;
        tick();

        // reset during RUN
        ch_req        = 4'b0001;
        ch_len[15:0]  = 16'd20;
        ch_data_av    = 4'b0001;
        tick();
        tick();
        tick();
        chk("mr_av_run", enc_data_av, 1);
        reset = 1'b1;
        #1;
        chk("mr_grant", ch_grant, 0);
        chk("mr_encrst", enc_reset, 1);
        chk("mr_av", enc_data_av, 0);
        chk("mr_len", enc_len, 0);
        chk("mr_chk", checksum_out, 0);
        tick();
        chk("mr_nodone", ch_done, 0);
        reset = 1'b0;
        tick();
        chk("mr_regrant", ch_grant, 4'b0001);
        chk("mr_start", enc_start, 1);
        chk("mr_len2", enc_len, 20);
        tick();
        enc_fin = 1'b1;
        tick();
        chk("mr_done", ch_done, 4'b0001);
        ch_req     = '0;
        enc_fin    = 1'b0;
        ch_data_av = '0;
        tick();

        // round-robin with 1011 held from reset
        reset  = 1'b1;
        ch_req = 4'b1011;
        tick();
        reset = 1'b0;
        rr_exp[0] = 4'b0001;
        rr_exp[1] = 4'b0010;
        rr_exp[2] = 4'b1000;
        rr_exp[3] = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rr_grant%0d", i), ch_grant, rr_exp[i]);
            chk($sformatf("rr_start%0d", i), enc_start, 1);
            tick();
            enc_fin = 1'b1;
            tick();
            chk($sformatf("rr_done%0d", i), ch_done, rr_exp[i]);
            enc_fin = 1'b0;
            tick();
            chk($sformatf("rr_gap%0d", i), enc_start, 0);
        end
        ch_req = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/udp_tx_scheduler.md
# udp_tx_scheduler

Shares one `UDP_encoder` instance between `NUM_CH` transmit requesters. The block arbitrates round-robin, latches the winner's header fields, and pulses the encoder `start`. It forwards the winner's payload stream, waits for `fin`, and returns the checksum to the winner. Because the encoder's FIN state is sticky, the scheduler also owns the encoder reset and clears the encoder after every packet.

## Interface
- `NUM_CH`, 4: number of requesters, 2..8.
- `TIMEOUT_CYC`, 4096: maximum cycles in RUN before the packet is aborted.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `local_ip`  in  32  source IP, driven to `enc_src_ip` unchanged.
- `ch_req`  in  NUM_CH  per-channel request; held high until `ch_done`.
- `ch_src_port`, `ch_dest_port`, `ch_len`  in  16*NUM_CH  packed header fields; channel i occupies bits [16i+15:16i].
- `ch_dest_ip`  in  32*NUM_CH  packed destination IPs.
- `ch_no_chksum`  in  NUM_CH  per-channel checksum disable.
- `ch_data`  in  32*NUM_CH  packed payload words.
- `ch_data_av`  in  NUM_CH  payload-word valid.
- `ch_grant`  out  NUM_CH  one-hot grant; high from LAUNCH through DONE.
- `ch_done`  out  NUM_CH  one-cycle completion pulse to the winner.
- `ch_err`  out  1  asserted together with `ch_done` when the packet timed out.
- `checksum_out`  out  16  checksum of the last packet; holds until the next DONE.
- `enc_src_ip`, `enc_dest_ip`, `enc_data`  out  32  encoder inputs.
- `enc_src_port`, `enc_dest_port`, `enc_len`  out  16  encoder inputs.
- `enc_no_chksum`, `enc_start`, `enc_data_av`, `enc_reset`  out  1  encoder controls.
- `enc_fin`  in  1  encoder finish flag.
- `enc_checksum`  in  16  encoder checksum.

## Operation
- **States:**
  - IDLE → LAUNCH when any `ch_req` is high.
  - LAUNCH → RUN unconditionally.
  - RUN → DONE on `enc_fin`, or when the timeout counter reaches `TIMEOUT_CYC-1`.
  - DONE → IDLE unconditionally.
- **Arbitration (IDLE to LAUNCH edge):**
  - Round-robin priority starts at `(last_grant+1) mod NUM_CH`.
  - After reset, channel 0 has highest priority.
  - The pointer updates only when a grant is issued.
- **Header latch (same edge):** the winner's `src_port`, `dest_port`, `len`, `dest_ip` and `no_chksum` are captured into registers. The `enc_*` header outputs come only from these registers, so requesters may change their fields after the grant.
- **Encoder start:** `enc_start` = (state==LAUNCH), a one-cycle pulse.
- **Payload forwarding:**
  - `enc_data` = `ch_data` of the granted channel, combinational.
  - `enc_data_av` = `ch_data_av[g]` in LAUNCH and RUN; 0 otherwise.
  - Non-granted channels' `data_av` is ignored.
- **DONE:**
  - `ch_done[g]`=1 for one cycle.
  - `checksum_out` ← `enc_checksum` on normal completion, or 0 on timeout.
  - `ch_err` = timeout flag.
- **Encoder reset:** `enc_reset` = `reset` OR (state==DONE), so the encoder returns to IDLE before the next LAUNCH.
- **Request dropped mid-packet:** ignored; the packet runs to DONE.
- **Timeout counter:** 0 on entry to RUN, increments every RUN cycle, saturates, and is sized as $clog2(TIMEOUT_CYC).

## Timing
- **Reset values:**
  - state IDLE, pointer 0.
  - `ch_grant`, `ch_done`, `ch_err`, `checksum_out` = 0.
  - `enc_start`, `enc_data_av` = 0; `enc_reset` = 1 while `reset` is high.
  - Latched header registers = 0.
- **Request to start:** `ch_req` high in cycle t gives LAUNCH and `enc_start` in cycle t+1.
- **Fin to done:** `enc_fin` high in cycle f gives DONE in cycle f+1.
- **Back-to-back packets:** minimum gap is DONE, IDLE, LAUNCH, so the next `enc_start` comes 2 cycles after `ch_done`.
- **Simultaneous events:**
  - A new `ch_req` arriving in DONE is considered only in IDLE.
  - `enc_fin` and timeout in the same cycle count as a normal completion (`ch_err`=0).
- **Reset mid-RUN:** everything returns to reset values immediately. No `ch_done` is issued. The encoder is reset through `enc_reset`.

## Structure
- **Shared package `udp_pkg`:** state encoding (IDLE=0, LAUNCH=1, RUN=2, DONE=3) and the UDP protocol constant 17.
- **Sub-module `rr_arbiter`:** parameterised `NUM_CH`. Ports: `req`, pointer in, one-hot `grant` out, index out; combinational.
- **Top level:** state machine, header registers, muxes, timeout counter.

## Test plan
- **Single packet:** `ch_req[2]` with `len`=8, two data words, `enc_fin` 4 cycles after `enc_start` → `ch_grant`=4'b0100; `enc_start` pulses once; `ch_done[2]` pulses; `checksum_out` = `enc_checksum`.
- **Round-robin order:** `ch_req`=4'b1011 held continuously from reset → grants issued in order ch0, ch1, ch3, ch0.
- **Header latch:** change `ch_len[1]` from 12 to 40 after the grant → `enc_len` stays 12 until DONE.
- **Timeout:** `TIMEOUT_CYC`=16, `enc_fin` never asserted → DONE 16 cycles after RUN entry; `ch_err`=1; `checksum_out`=0; `enc_reset` high for one cycle.
- **Reset mid-packet:** assert `reset` in RUN → all outputs return to reset values asynchronously; no `ch_done`; after release, `ch_req[0]` is granted normally.
- **Non-granted data:** `ch_data_av` on a non-granted channel toggles during RUN → `enc_data_av` follows only the granted channel.
